// File: rtl/ram_sync_dp.sv
// ram_sync_dp: simple dual-port synchronous RAM (one write port, one read port).
// Byte-enable writes, selectable read-during-write behaviour, optional output
// register, read-valid flag and a clear engine that zeroes the array after
// reset or on request.
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset; restarts the clear sweep
//   clr       single-cycle request to zero the array (ignored while busy)
//   busy      high while the clear engine owns the array
//   we        write enable
//   wr_addr   write address
//   wr_data   write data
//   wr_be     byte enables, bit i covers wr_data[8i+7:8i]
//   re        read enable
//   rd_addr   read address
//   rd_data   read data, holds its last value when no read completes
//   rd_valid  rd_data carries the result of an accepted read
module ram_sync_dp #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned OUT_REG  = 0,
  parameter int unsigned RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  output logic                busy,
  input  logic                we,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                re,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned NB    = DATA_W / 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic                busy_q, busy_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  // Shared write port: either the clear engine or the user write
  logic                mem_wen;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [NB-1:0]       mem_wbe;
  logic [DATA_W-1:0]   wr_merged;
  logic                rd_acc;
  logic [DATA_W-1:0]   rd_word;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= busy_d;
    end
  end

  // Next state, write-port arbitration and read acceptance
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    busy_d    = busy_q;
    mem_wen   = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    mem_wbe   = wr_be;
    rd_acc    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        mem_wen   = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        mem_wbe   = '1;
        clr_ptr_d = ADDR_W'(clr_ptr_q + 1'b1);
        if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d   = ST_IDLE;
          clr_ptr_d = '0;
          busy_d    = 1'b0;
        end
      end
      ST_IDLE: begin
        if (clr) begin
          // Any we/re sampled together with clr is dropped
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
          busy_d    = 1'b1;
        end else begin
          mem_wen = we;
          rd_acc  = re;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
    // Array contents are left alone while reset is held
    if (rst) begin
      mem_wen = 1'b0;
      rd_acc  = 1'b0;
    end
  end

  // Byte merge of the incoming write with the currently stored word
  for (genvar b = 0; b < NB; b++) begin : g_byte
    assign wr_merged[8*b +: 8] = mem_wbe[b] ? mem_wdata[8*b +: 8]
                                            : mem_q[mem_waddr][8*b +: 8];
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (mem_wen) begin
      mem_q[mem_waddr] <= wr_merged;
    end
  end

  // Write-first forwarding: the merged word is exactly what the array will hold
  always_comb begin
    rd_word = mem_q[rd_addr];
    if ((RDW_MODE != 0) && mem_wen && (mem_waddr == rd_addr)) begin
      rd_word = wr_merged;
    end
  end

  // First read stage (latency 1)
  logic [DATA_W-1:0] s1_data_q;
  logic              s1_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= rd_acc;
      if (rd_acc) begin
        s1_data_q <= rd_word;
      end
    end
  end

  // Optional output stage (latency 2)
  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] s2_data_q;
    logic              s2_valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_data_q  <= '0;
        s2_valid_q <= 1'b0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= s1_data_q;
        end
      end
    end

    assign rd_data  = s2_data_q;
    assign rd_valid = s2_valid_q;
  end else begin : g_no_out_reg
    assign rd_data  = s1_data_q;
    assign rd_valid = s1_valid_q;
  end

  assign busy = busy_q;

endmodule
